// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - event pulse to fixed-length LED blink stretcher with replay queue (optional Clear via PULSE_STRETCHER_CLEAR_EN)
module pulse_stretcher #(
  parameter int ON_CYCLES  = 5000000,
  parameter int GAP_CYCLES = 5000000,
  parameter int PEND_W     = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Pulse,
`ifdef PULSE_STRETCHER_CLEAR_EN
  input  logic              Clear,
`endif
  output logic              Led,
  output logic              Busy,
  output logic [PEND_W-1:0] Pending,
  output logic              Overflow
);

  // Timer is sized for the longer of the two windows; it is cleared on
  // every state change so it never needs to wrap.
  localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0]     ON_LAST   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] QUEUE_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;

  logic clear_req;
  logic on_done;
  logic gap_done;
  logic enq;
  logic deq;

`ifdef PULSE_STRETCHER_CLEAR_EN
  assign clear_req = Clear;
`else
  assign clear_req = 1'b0;
`endif

  // Window end markers, true on the last cycle of each timed state.
  assign on_done  = (state_q == ST_ON)  && (timer_q == ON_LAST);
  assign gap_done = (state_q == ST_GAP) && (timer_q == GAP_LAST);

  // A pulse while busy is queued; a replay is taken off the queue at the
  // end of a gap when something is waiting.
  assign enq = Pulse && (state_q != ST_IDLE);
  assign deq = gap_done && (pending_q != '0);

  // State register plus all registered outputs and counters.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: IDLE -> ON on an event, ON -> GAP after the on window,
  // GAP -> ON (replay) or IDLE after the gap; Clear forces IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (Pulse)    state_d = ST_ON;
      ST_ON:   if (on_done)  state_d = ST_GAP;
      ST_GAP:  if (gap_done) state_d = (pending_q != '0) ? ST_ON : ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
    if (clear_req) begin
      state_d = ST_IDLE;
    end
  end

  // Timer, queue and overflow updates, plus the registered LED/Busy drives
  // derived from the upcoming state so they line up with it.
  always_comb begin
    timer_d    = timer_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (state_d != state_q || state_q == ST_IDLE) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    if (enq && !deq) begin
      if (pending_q == QUEUE_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (deq && !enq) begin
      pending_d = pending_q - 1'b1;
    end

    if (clear_req) begin
      timer_d    = '0;
      pending_d  = '0;
      overflow_d = 1'b0;
    end

    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  assign Led      = led_q;
  assign Busy     = busy_q;
  assign Pending  = pending_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed self-checking bench for pulse_stretcher
`timescale 1ns/1ps
module tb_pulse_stretcher;

  localparam int ON_CYCLES  = 4;
  localparam int GAP_CYCLES = 2;
  localparam int PEND_W     = 2;

  logic              Clk;
  logic              Rst_n;
  logic              Pulse;
  logic              Clear;
  logic              Led;
  logic              Busy;
  logic [PEND_W-1:0] Pending;
  logic              Overflow;

  int checks;
  int errors;

  logic [63:0]       led_v;
  logic [63:0]       busy_v;
  logic [63:0]       ovf_v;
  logic [PEND_W-1:0] pend_tr [0:63];

  pulse_stretcher #(
    .ON_CYCLES (ON_CYCLES),
    .GAP_CYCLES(GAP_CYCLES),
    .PEND_W    (PEND_W)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Pulse   (Pulse),
`ifdef PULSE_STRETCHER_CLEAR_EN
    .Clear   (Clear),
`endif
    .Led     (Led),
    .Busy    (Busy),
    .Pending (Pending),
    .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Cycle i: inputs driven just after posedge i, outputs sampled at the
  // following negedge, so a pulse in cycle i shows its effect in cycle i+1.
  task automatic run_trace(input logic [63:0] pulses, input logic [63:0] clears, input int n);
    led_v  = '0;
    busy_v = '0;
    ovf_v  = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      Pulse = pulses[i];
      Clear = clears[i];
      @(negedge Clk);
      led_v[i]   = Led;
      busy_v[i]  = Busy;
      ovf_v[i]   = Overflow;
      pend_tr[i] = Pending;
    end
    @(posedge Clk);
    #1;
    Pulse = 1'b0;
    Clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Start a blink with one queued event, then assert reset mid-ON.
    run_trace(64'h0C, 64'h0, 5);
    checks++;
    if (led_v[4] !== 1'b1 || pend_tr[4] !== 2'd1) begin
      errors++;
      $display("FAIL reset_pre led=%b pend=%0d want led=1 pend=1", led_v[4], pend_tr[4]);
    end
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (Led !== 1'b0 || Busy !== 1'b0 || Pending !== 2'd0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_async led=%b busy=%b pend=%0d ovf=%b want all 0", Led, Busy, Pending, Overflow);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    run_trace(64'h0, 64'h0, 10);
    checks++;
    if (led_v !== 64'h0 || busy_v !== 64'h0) begin
      errors++;
      $display("FAIL reset_release led=%h busy=%h want 0 0", led_v, busy_v);
    end
  endtask

  task automatic test_single();
    do_reset();
    run_trace(64'h1 << 10, 64'h0, 24);
    checks++;
    if (led_v[23:0] !== 24'h007800) begin
      errors++;
      $display("FAIL single_led got=%h want=%h", led_v[23:0], 24'h007800);
    end
    checks++;
    if (busy_v[23:0] !== 24'h01F800) begin
      errors++;
      $display("FAIL single_busy got=%h want=%h", busy_v[23:0], 24'h01F800);
    end
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (pend_tr[i] !== 2'd0) begin
        errors++;
        $display("FAIL single_pending cycle=%0d got=%0d want=0", i, pend_tr[i]);
      end
    end
  endtask

  task automatic test_queued();
    logic [1:0] exp_p [0:31];
    do_reset();
    run_trace((64'h1 << 10) | (64'h1 << 12) | (64'h1 << 13), 64'h0, 32);
    for (int i = 0; i < 32; i++) begin
      if (i == 13)                exp_p[i] = 2'd1;
      else if (i >= 14 && i <= 16) exp_p[i] = 2'd2;
      else if (i >= 17 && i <= 22) exp_p[i] = 2'd1;
      else                         exp_p[i] = 2'd0;
    end
    checks++;
    if (led_v[31:0] !== 32'h079E7800) begin
      errors++;
      $display("FAIL queued_led got=%h want=%h", led_v[31:0], 32'h079E7800);
    end
    checks++;
    if (busy_v[31:0] !== 32'h1FFFF800) begin
      errors++;
      $display("FAIL queued_busy got=%h want=%h", busy_v[31:0], 32'h1FFFF800);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (pend_tr[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL queued_pending cycle=%0d got=%0d want=%0d", i, pend_tr[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int blinks;
    logic [63:0] exp_ovf;
    do_reset();
    run_trace(64'hFC00, 64'h0, 40);
    exp_ovf = ((64'h1 << 40) - 1) ^ ((64'h1 << 15) - 1);
    checks++;
    if (led_v[39:0] !== 40'h01E79E7800) begin
      errors++;
      $display("FAIL sat_led got=%h want=%h", led_v[39:0], 40'h01E79E7800);
    end
    checks++;
    if (ovf_v !== exp_ovf) begin
      errors++;
      $display("FAIL sat_overflow got=%h want=%h", ovf_v, exp_ovf);
    end
    checks++;
    if (pend_tr[14] !== 2'd3 || pend_tr[16] !== 2'd3 || pend_tr[17] !== 2'd2 || pend_tr[35] !== 2'd0) begin
      errors++;
      $display("FAIL sat_pending p14=%0d p16=%0d p17=%0d p35=%0d want 3 3 2 0",
               pend_tr[14], pend_tr[16], pend_tr[17], pend_tr[35]);
    end
    blinks = 0;
    for (int i = 1; i < 40; i++) begin
      if (led_v[i] && !led_v[i-1]) blinks++;
    end
    checks++;
    if (blinks !== 4) begin
      errors++;
      $display("FAIL sat_blinks got=%0d want=4", blinks);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_trace((64'h1 << 10) | (64'h1 << 12) | (64'h1 << 16), 64'h0, 32);
    checks++;
    if (pend_tr[16] !== 2'd1 || pend_tr[17] !== 2'd1 || pend_tr[23] !== 2'd0) begin
      errors++;
      $display("FAIL b2b_pending p16=%0d p17=%0d p23=%0d want 1 1 0", pend_tr[16], pend_tr[17], pend_tr[23]);
    end
    checks++;
    if (led_v[31:0] !== 32'h079E7800) begin
      errors++;
      $display("FAIL b2b_led got=%h want=%h", led_v[31:0], 32'h079E7800);
    end
    checks++;
    if (busy_v[31:0] !== 32'h1FFFF800) begin
      errors++;
      $display("FAIL b2b_busy got=%h want=%h", busy_v[31:0], 32'h1FFFF800);
    end
  endtask

`ifdef PULSE_STRETCHER_CLEAR_EN
  task automatic test_clear();
    do_reset();
    // Overflow at 15, Pending back to 2 at 17, Clear with Pulse in ON at 18.
    run_trace(64'hFC00 | (64'h1 << 18), 64'h1 << 18, 36);
    checks++;
    if (led_v[18] !== 1'b1 || pend_tr[18] !== 2'd2 || ovf_v[18] !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre led=%b pend=%0d ovf=%b want 1 2 1", led_v[18], pend_tr[18], ovf_v[18]);
    end
    checks++;
    if (led_v[35:19] !== 17'h0 || busy_v[35:19] !== 17'h0 || ovf_v[35:19] !== 17'h0 || pend_tr[19] !== 2'd0) begin
      errors++;
      $display("FAIL clear_post led=%h busy=%h ovf=%h pend=%0d want 0 0 0 0",
               led_v[35:19], busy_v[35:19], ovf_v[35:19], pend_tr[19]);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    Rst_n  = 1'b0;
    Pulse  = 1'b0;
    Clear  = 1'b0;
    #1;
    checks++;
    if (Led !== 1'b0 || Busy !== 1'b0 || Pending !== 2'd0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state led=%b busy=%b pend=%0d ovf=%b want all 0", Led, Busy, Pending, Overflow);
    end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    test_reset();
    test_single();
    test_queued();
    test_saturation();
    test_back_to_back();
`ifdef PULSE_STRETCHER_CLEAR_EN
    test_clear();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart of the button debouncer. It turns single-cycle clean event pulses into human-visible LED blinks.
- Each accepted event produces one LED-on window of fixed length, followed by a mandatory off gap.
- Events that arrive while a blink is in progress are queued in a saturating counter and replayed in order.
- Sits between the debounced-event logic and a board LED pin.

Parameters:
- ON_CYCLES, 5000000, LED-on duration per event in Clk cycles (50 ms at 100 MHz); must be >= 1.
- GAP_CYCLES, 5000000, forced LED-off duration after each blink in Clk cycles; must be >= 1.
- PEND_W, 4, width of the pending-event counter; queue capacity QUEUE_MAX = 2^PEND_W - 1.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Pulse  input  1  event strobe; every cycle it is high counts as one event.
- Led  output  1  registered LED drive; 1 = lit.
- Busy  output  1  high whenever the FSM is not IDLE.
- Pending  output  PEND_W  number of queued events not yet started.
- Overflow  output  1  sticky flag: an event was dropped because the queue was full.

Behaviour:
- Clock and reset: one clock, Clk. Reset is Rst_n, asynchronous and active-low.
- Reset (Rst_n = 0, asynchronous):
  - FSM goes to IDLE.
  - Led=0, Busy=0, Pending=0, Overflow=0, timer=0.
  - Release of reset is synchronous to Clk.
- Timer width: ceil(log2(max(ON_CYCLES, GAP_CYCLES)+1)) bits. It counts up from 0 and never wraps.
- FSM states: IDLE, ON, GAP.
- IDLE:
  - Led=0.
  - Pulse=1 -> ON on the next edge; Led=1 from cycle n+1 when Pulse is seen at cycle n.
  - The event is consumed directly; Pending is unchanged.
- ON:
  - Led=1 for exactly ON_CYCLES consecutive cycles.
  - At the end -> GAP with timer cleared.
- GAP:
  - Led=0 for exactly GAP_CYCLES cycles.
  - At the end: if Pending>0, decrement Pending and go to ON; else go to IDLE.
- Queueing: Pulse=1 in ON or GAP increments Pending.
  - The last cycle of GAP is included.
  - Exception: when a decrement happens in the same cycle, the net change to Pending is 0.
- Saturation: if Pending==QUEUE_MAX and the increment is not offset by a decrement:
  - Pending holds at QUEUE_MAX.
  - Overflow sets to 1 and remains 1 until reset.
- Busy = (state != IDLE); registered alongside the state.
- Back-to-back events: when GAP ends into ON, the first ON cycle follows the last GAP cycle immediately. No IDLE cycle is inserted.
- A Pulse held high for k cycles counts as k events.
- Reset mid-blink: Led drops to 0 immediately (asynchronous) and the queue is discarded.

Optional Feature:
- Macro: PULSE_STRETCHER_CLEAR_EN.
- With the macro defined:
  - Adds input port Clear (1 bit), a synchronous flush.
  - Clear=1 at cycle n -> at n+1: state IDLE, Led=0, Busy=0, Pending=0, Overflow=0, timer=0.
  - Clear has priority over a Pulse in the same cycle; that Pulse is dropped and does not set Overflow.
- Without the macro:
  - No Clear port exists.
  - Overflow clears only on reset.
  - Pending empties only by replay.

Test Plan (ON_CYCLES=4, GAP_CYCLES=2, PEND_W=2, QUEUE_MAX=3):
- Reset: assert Rst_n=0 mid-ON -> Led, Busy, Pending, Overflow read 0 in the same cycle, before any Clk edge. Release -> module stays in IDLE with Led=0.
- Single event: Pulse at cycle 10 -> Led=1 for cycles 11-14, Led=0 for 15-16, Busy=0 from cycle 17. Pending stays 0 throughout.
- Queued events: Pulses at cycles 10, 12, 13 -> Pending reads 1 then 2. Blinks start at cycles 11, 17 and 23. Pending decrements on entry to ON at 17 and 23. Busy falls at 29.
- Saturation: Pulse held high for cycles 10-15 -> first event starts a blink, Pending saturates at 3, Overflow=1 from cycle 15 and stays set. Exactly 4 blinks total are produced.
- Simultaneous increment/decrement: Pending=1 and Pulse=1 on the final GAP cycle -> Pending stays 1 and the next ON starts with no idle cycle.
- Clear (macro defined): Clear together with Pulse during ON with Pending=2 and Overflow=1 -> next cycle Led=0, Pending=0, Overflow=0, IDLE, and no further blinks.
